// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the timer controller: register indices, register
// bit positions and the command sequencer state encoding.
package timer_ctrl_pkg;

   localparam logic [2:0] REG_CTRL      = 3'd0;
   localparam logic [2:0] REG_CMD       = 3'd1;
   localparam logic [2:0] REG_TERMCOUNT = 3'd2;
   localparam logic [2:0] REG_STATUS    = 3'd3;
   localparam logic [2:0] REG_CURRCOUNT = 3'd4;
   localparam logic [2:0] REG_INTCLR    = 3'd5;

   localparam int CTRL_MODE_BIT   = 0;
   localparam int CTRL_IRQ_EN_BIT = 1;

   localparam int CMD_START_BIT = 0;
   localparam int CMD_HALT_BIT  = 1;

   // INTCLR uses the same bit positions as the low STATUS flags
   localparam int STAT_PENDING_BIT = 0;
   localparam int STAT_OVERRUN_BIT = 1;
   localparam int STAT_CMD_ERR_BIT = 2;
   localparam int STAT_SHADOW_BIT  = 3;
   localparam int STAT_STATE_LSB   = 4;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_STARTING = 2'd1,
      ST_RUNNING  = 2'd2,
      ST_STOPPING = 2'd3
   } seq_state_e;

endpackage

// File: rtl/timer_ctrl_seq.sv
// Command sequencer: tracks the timer lifecycle, emits one-cycle start/halt
// pulses and flags commands that are illegal in the current state.
module timer_ctrl_seq
   import timer_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   input  logic [1:0] cmd_bits,
   input  logic       rf_status,
   output logic       ro_trig_start,
   output logic       ro_trig_halt,
   output seq_state_e state,
   output logic       cmd_err
);

   seq_state_e state_q, state_d;
   logic       trig_start_q, trig_start_d;
   logic       trig_halt_q, trig_halt_d;
   logic       want_start, want_halt;

   always_comb begin
      // Halt takes precedence when both command bits are set
      want_halt    = cmd_valid & cmd_bits[CMD_HALT_BIT];
      want_start   = cmd_valid & cmd_bits[CMD_START_BIT] & ~cmd_bits[CMD_HALT_BIT];
      state_d      = state_q;
      trig_start_d = 1'b0;
      trig_halt_d  = 1'b0;
      cmd_err      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (want_start) begin
               trig_start_d = 1'b1;
               state_d      = ST_STARTING;
            end else if (want_halt) begin
               cmd_err = 1'b1;
            end
         end
         ST_STARTING: begin
            if (want_start || want_halt) cmd_err = 1'b1;
            if (rf_status) state_d = ST_RUNNING;
         end
         ST_RUNNING: begin
            if (want_halt) begin
               trig_halt_d = 1'b1;
               state_d     = ST_STOPPING;
            end else begin
               if (want_start) cmd_err = 1'b1;
               if (!rf_status) state_d = ST_IDLE;
            end
         end
         ST_STOPPING: begin
            if (want_start || want_halt) cmd_err = 1'b1;
            if (!rf_status) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         trig_start_q <= 1'b0;
         trig_halt_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         trig_start_q <= trig_start_d;
         trig_halt_q  <= trig_halt_d;
      end
   end

   assign ro_trig_start = trig_start_q;
   assign ro_trig_halt  = trig_halt_q;
   assign state         = state_q;

endmodule

// File: rtl/timer_ctrl.sv
// Bus-mapped timer controller: register decode, sticky interrupt flags and
// read mux. Define TIMER_SHADOW_EN to buffer TERMCOUNT writes made while running.
module timer_ctrl
   import timer_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        bus_we,
   input  logic        bus_re,
   input  logic [2:0]  bus_addr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        bus_ack,
   output logic        ro_trig_start,
   output logic        ro_trig_halt,
   output logic        ro_mode,
   output logic [31:0] ro_termcount,
   input  logic        rf_status,
   input  logic [31:0] rf_currcount,
   input  logic        rf_int,
   output logic        irq
);

   seq_state_e  seq_state;
   logic        seq_cmd_err;
   logic        wr_ctrl, wr_cmd, wr_term, wr_intclr, is_idle, reg_err;
   logic        shadow_flag;
   logic        mode_q, mode_d, irq_en_q, irq_en_d;
   logic [31:0] termcount_q, termcount_d;
   logic        pending_q, pending_d, overrun_q, overrun_d, cmd_err_q, cmd_err_d;
   logic        ack_q, ack_d;
   logic [31:0] rdata_q, rdata_d, status_word;
`ifdef TIMER_SHADOW_EN
   logic [31:0] shadow_q, shadow_d;
   logic        shadow_valid_q, shadow_valid_d;
`endif

   timer_ctrl_seq u_seq (
      .clk           (clk),
      .reset         (reset),
      .cmd_valid     (wr_cmd),
      .cmd_bits      (bus_wdata[1:0]),
      .rf_status     (rf_status),
      .ro_trig_start (ro_trig_start),
      .ro_trig_halt  (ro_trig_halt),
      .state         (seq_state),
      .cmd_err       (seq_cmd_err)
   );

   always_comb begin
      wr_ctrl     = bus_we && (bus_addr == REG_CTRL);
      wr_cmd      = bus_we && (bus_addr == REG_CMD);
      wr_term     = bus_we && (bus_addr == REG_TERMCOUNT);
      wr_intclr   = bus_we && (bus_addr == REG_INTCLR);
      is_idle     = (seq_state == ST_IDLE);
      reg_err     = 1'b0;
      mode_d      = mode_q;
      irq_en_d    = irq_en_q;
      termcount_d = termcount_q;
      if (wr_ctrl) begin
         if (is_idle) begin
            mode_d   = bus_wdata[CTRL_MODE_BIT];
            irq_en_d = bus_wdata[CTRL_IRQ_EN_BIT];
         end else begin
            reg_err = 1'b1;
         end
      end
`ifdef TIMER_SHADOW_EN
      shadow_d       = shadow_q;
      shadow_valid_d = shadow_valid_q;
      // A buffered count takes effect at the terminal pulse of the current period
      if (rf_int && shadow_valid_q) begin
         termcount_d    = shadow_q;
         shadow_valid_d = 1'b0;
      end
      if (wr_term) begin
         if (is_idle) begin
            termcount_d = bus_wdata;
         end else begin
            shadow_d       = bus_wdata;
            shadow_valid_d = 1'b1;
         end
      end
      shadow_flag = shadow_valid_q;
`else
      if (wr_term) begin
         if (is_idle) termcount_d = bus_wdata;
         else         reg_err     = 1'b1;
      end
      shadow_flag = 1'b0;
`endif
   end

   // Sticky flags: a same-cycle set always wins over a write-1 clear
   always_comb begin
      pending_d = pending_q;
      overrun_d = overrun_q;
      cmd_err_d = cmd_err_q;
      if (wr_intclr && bus_wdata[STAT_PENDING_BIT]) pending_d = 1'b0;
      if (wr_intclr && bus_wdata[STAT_OVERRUN_BIT]) overrun_d = 1'b0;
      if (wr_intclr && bus_wdata[STAT_CMD_ERR_BIT]) cmd_err_d = 1'b0;
      if (rf_int)                   pending_d = 1'b1;
      if (rf_int && pending_q)      overrun_d = 1'b1;
      if (reg_err || seq_cmd_err)   cmd_err_d = 1'b1;
   end

   always_comb begin
      status_word = {26'd0, seq_state, shadow_flag, cmd_err_q, overrun_q, pending_q};
      ack_d       = bus_we | bus_re;
      rdata_d     = '0;
      if (bus_re) begin
         case (bus_addr)
            REG_CTRL: begin
               rdata_d[CTRL_MODE_BIT]   = mode_q;
               rdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
            end
            REG_TERMCOUNT: rdata_d = termcount_q;
            REG_STATUS:    rdata_d = status_word;
            REG_CURRCOUNT: rdata_d = rf_currcount;
            default:       rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q      <= 1'b0;
         irq_en_q    <= 1'b0;
         termcount_q <= '0;
         pending_q   <= 1'b0;
         overrun_q   <= 1'b0;
         cmd_err_q   <= 1'b0;
         ack_q       <= 1'b0;
         rdata_q     <= '0;
      end else begin
         mode_q      <= mode_d;
         irq_en_q    <= irq_en_d;
         termcount_q <= termcount_d;
         pending_q   <= pending_d;
         overrun_q   <= overrun_d;
         cmd_err_q   <= cmd_err_d;
         ack_q       <= ack_d;
         rdata_q     <= rdata_d;
      end
   end

`ifdef TIMER_SHADOW_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_q       <= '0;
         shadow_valid_q <= 1'b0;
      end else begin
         shadow_q       <= shadow_d;
         shadow_valid_q <= shadow_valid_d;
      end
   end
`endif

   assign ro_mode      = mode_q;
   assign ro_termcount = termcount_q;
   assign bus_ack      = ack_q;
   assign bus_rdata    = rdata_q;
   assign irq          = pending_q & irq_en_q;

endmodule
